// File: rtl/jkff_bank_if.sv
// -----------------------------------------------------------------------------
// jkff_bank_if
// Bundles the data/control signals of a jkff_bank. clk and rst_n stay plain
// ports on the bank itself.
//
// Signals (direction seen from the bank, i.e. the slave modport):
//   en       in   update enable; 0 = hold (load still honoured)
//   mode     in   00 JK, 01 D, 10 T, 11 modulo up/down counter
//   jk       in   per-bit pair, jk[2i+1] = J_i, jk[2i] = K_i
//   d        in   D data / T toggle mask / parallel load data
//   load     in   parallel load of d into q (beats en)
//   dir      in   count direction in mode 11: 1 up, 0 down
//   q        out  registered state
//   qb       out  ~q
//   tc       out  terminal count (combinational)
//   changed  out  registered, 1 for one cycle after q changed
// -----------------------------------------------------------------------------
interface jkff_bank_if #(
  parameter int WIDTH = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [2*WIDTH-1:0] jk;
  logic [WIDTH-1:0]   d;
  logic               load;
  logic               dir;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qb;
  logic               tc;
  logic               changed;

  // Driver side (testbench or surrounding logic).
  modport master (
    output en, mode, jk, d, load, dir,
    input  q, qb, tc, changed
  );

  // The flip-flop bank.
  modport slave (
    input  en, mode, jk, d, load, dir,
    output q, qb, tc, changed
  );
endinterface

// File: rtl/jkff_bank.sv
// -----------------------------------------------------------------------------
// jkff_bank
// A bank of WIDTH flip-flops on one clock that can behave, selected at run
// time, as independent JK, D or T flip-flops or as a synchronous modulo
// up/down counter. Parallel load and a synchronous active-low reset are
// available in every mode.
//
// Parameters:
//   WIDTH      number of bits, 1..16
//   RESET_VAL  value of q after reset
//   MODULUS    counter modulus in count mode, 2..2**WIDTH
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active-low
//   bus    slave side of jkff_bank_if (en, mode, jk, d, load, dir in;
//          q, qb, tc, changed out)
//
// Edge priority: reset, then load, then en, otherwise hold.
// -----------------------------------------------------------------------------
module jkff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               MODULUS   = 2 ** WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  jkff_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_JK  = 2'b00,
    MODE_D   = 2'b01,
    MODE_T   = 2'b10,
    MODE_CNT = 2'b11
  } mode_e;

  // Largest legal count value; MODULUS <= 2**WIDTH so it always fits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] cnt_next;
  mode_e            mode_s;

  assign mode_s = mode_e'(bus.mode);

  // ---------------------------------------------------------------------------
  // Per-bit JK behaviour. Each bit only looks at its own J/K pair and its own
  // current value, so the bits are fully independent.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    jk_next = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.jk[2*i +: 2])
        2'b00:   jk_next[i] = q_q[i];   // J=0 K=0 hold
        2'b01:   jk_next[i] = 1'b0;     // J=0 K=1 reset
        2'b10:   jk_next[i] = 1'b1;     // J=1 K=0 set
        default: jk_next[i] = ~q_q[i];  // J=1 K=1 toggle
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Modulo counter. Up-count uses >= so an out-of-range value (only reachable
  // via load or RESET_VAL) wraps to 0; down-count of such a value simply
  // decrements. Arithmetic stays WIDTH bits, carry is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_next = q_q;
    if (bus.dir) begin
      cnt_next = (q_q >= MAX_VAL) ? '0 : q_q + WIDTH'(1);
    end else begin
      cnt_next = (q_q == '0) ? MAX_VAL : q_q - WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state selection: load beats en; en = 0 holds. Reset is applied in the
  // register process.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_d = q_q;
    if (bus.load) begin
      q_d = bus.d;
    end else if (bus.en) begin
      case (mode_s)
        MODE_JK:  q_d = jk_next;
        MODE_D:   q_d = bus.d;
        MODE_T:   q_d = q_q ^ bus.d;
        MODE_CNT: q_d = cnt_next;
        default:  q_d = q_q;
      endcase
    end
  end

  assign changed_d = (q_d != q_q);

  // ---------------------------------------------------------------------------
  // State register with synchronous active-low reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      // NOTE: reset is synchronous here, so there is no reset in the
      // sensitivity list and q is unknown until the first clock edge.
      q_q       <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. tc flags the count value that is about to wrap, but only when the
  // coming edge will really perform a count (no reset, no load, enabled).
  // ---------------------------------------------------------------------------
  assign bus.q       = q_q;
  assign bus.qb      = ~q_q;
  assign bus.changed = changed_q;
  assign bus.tc      = rst_n && !bus.load && bus.en && (mode_s == MODE_CNT) &&
                       (bus.dir ? (q_q == MAX_VAL) : (q_q == '0));

endmodule

// File: tb/tb_jkff_bank.sv
// -----------------------------------------------------------------------------
// tb_jkff_bank
// Directed bench for jkff_bank. Two instances share clk and rst_n:
//   dut4: WIDTH 4, RESET_VAL 4'h5, MODULUS 10
//   dut1: WIDTH 1, defaults (legacy single-bit jkff behaviour)
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_jkff_bank;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  jkff_bank_if #(.WIDTH(4)) bus4 ();
  jkff_bank_if #(.WIDTH(1)) bus1 ();

  jkff_bank #(.WIDTH(4), .RESET_VAL(4'h5), .MODULUS(10)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  jkff_bank #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges while asking for a count, then reset mid-count.
  task automatic test_reset();
    rst_n     = 1'b0;
    bus4.en   = 1'b1;
    bus4.mode = 2'b11;
    bus4.dir  = 1'b1;
    bus4.load = 1'b0;
    bus4.jk   = '0;
    bus4.d    = '0;
    bus1.en   = 1'b0;
    bus1.mode = 2'b00;
    bus1.dir  = 1'b1;
    bus1.load = 1'b0;
    bus1.jk   = '0;
    bus1.d    = '0;
    tick();
    tick();
    n_checks++;
    if (bus4.q !== 4'h5) begin n_fail++; $display("FAIL reset_q: got %h want 5", bus4.q); end
    n_checks++;
    if (bus4.qb !== 4'hA) begin n_fail++; $display("FAIL reset_qb: got %h want a", bus4.qb); end
    n_checks++;
    if (bus4.changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b want 0", bus4.changed); end
    n_checks++;
    if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", bus4.tc); end
    n_checks++;
    if (bus1.q !== 1'b0) begin n_fail++; $display("FAIL reset_q_w1: got %b want 0", bus1.q); end

    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus4.q !== 4'h7) begin n_fail++; $display("FAIL count_after_reset: got %h want 7", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b1) begin n_fail++; $display("FAIL count_changed: got %b want 1", bus4.changed); end

    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus4.q !== 4'h5) begin n_fail++; $display("FAIL midcount_reset_q: got %h want 5", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b0) begin n_fail++; $display("FAIL midcount_reset_changed: got %b want 0", bus4.changed); end
    rst_n = 1'b1;
  endtask

  // Independent per-bit JK on the 4-bit bank.
  task automatic test_jk();
    bus4.load = 1'b1;
    bus4.d    = 4'h0;
    tick();
    n_checks++;
    if (bus4.q !== 4'h0) begin n_fail++; $display("FAIL jk_preload: got %h want 0", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b1) begin n_fail++; $display("FAIL jk_preload_changed: got %b want 1", bus4.changed); end

    bus4.load = 1'b0;
    bus4.en   = 1'b1;
    bus4.mode = 2'b00;
    bus4.jk   = 8'b10_01_11_00;
    tick();
    n_checks++;
    if (bus4.q !== 4'b1010) begin n_fail++; $display("FAIL jk_first: got %b want 1010", bus4.q); end
    tick();
    n_checks++;
    if (bus4.q !== 4'b1000) begin n_fail++; $display("FAIL jk_second: got %b want 1000", bus4.q); end
    n_checks++;
    if (bus4.qb !== 4'b0111) begin n_fail++; $display("FAIL jk_qb: got %b want 0111", bus4.qb); end

    bus4.jk = 8'b00_00_00_00;
    tick();
    n_checks++;
    if (bus4.q !== 4'b1000) begin n_fail++; $display("FAIL jk_hold: got %b want 1000", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b0) begin n_fail++; $display("FAIL jk_hold_changed: got %b want 0", bus4.changed); end
  endtask

  // Single-bit bank must behave like the legacy jkff: hold, reset, set, toggle.
  task automatic test_jk_width1();
    logic [1:0] jk_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
    logic       q_exp  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus1.en   = 1'b1;
    bus1.mode = 2'b00;
    for (int i = 0; i < 6; i++) begin
      bus1.jk = jk_seq[i];
      tick();
      n_checks++;
      if (bus1.q !== q_exp[i]) begin
        n_fail++;
        $display("FAIL jk_w1_step%0d: got %b want %b", i, bus1.q, q_exp[i]);
      end
    end
  endtask

  // D and T modes.
  task automatic test_d_t();
    logic [1:0] mode_seq [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    logic [3:0] d_seq    [4] = '{4'hC, 4'h3, 4'hF, 4'h0};
    logic [3:0] q_exp    [4] = '{4'hC, 4'hF, 4'h0, 4'h0};
    logic       ch_exp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus4.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus4.mode = mode_seq[i];
      bus4.d    = d_seq[i];
      tick();
      n_checks++;
      if (bus4.q !== q_exp[i]) begin
        n_fail++;
        $display("FAIL dt_q_step%0d: got %h want %h", i, bus4.q, q_exp[i]);
      end
      n_checks++;
      if (bus4.changed !== ch_exp[i]) begin
        n_fail++;
        $display("FAIL dt_changed_step%0d: got %b want %b", i, bus4.changed, ch_exp[i]);
      end
    end
  endtask

  // Up-count modulo 10 from 8, then hold with en = 0.
  task automatic test_count_up();
    logic [3:0] q_seq  [4] = '{4'd8, 4'd9, 4'd0, 4'd1};
    logic       tc_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bus4.load = 1'b1;
    bus4.d    = 4'd8;
    tick();
    bus4.load = 1'b0;
    bus4.mode = 2'b11;
    bus4.dir  = 1'b1;
    bus4.en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1;
      n_checks++;
      if (bus4.q !== q_seq[i]) begin
        n_fail++;
        $display("FAIL up_q_step%0d: got %0d want %0d", i, bus4.q, q_seq[i]);
      end
      n_checks++;
      if (bus4.tc !== tc_seq[i]) begin
        n_fail++;
        $display("FAIL up_tc_step%0d: got %b want %b", i, bus4.tc, tc_seq[i]);
      end
    end

    bus4.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus4.q !== 4'd1) begin n_fail++; $display("FAIL hold_q_%0d: got %0d want 1", i, bus4.q); end
      n_checks++;
      if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL hold_tc_%0d: got %b want 0", i, bus4.tc); end
      n_checks++;
      if (bus4.changed !== 1'b0) begin n_fail++; $display("FAIL hold_changed_%0d: got %b want 0", i, bus4.changed); end
    end
  endtask

  // Down-count wrap and out-of-range behaviour.
  task automatic test_count_down();
    bus4.mode = 2'b11;
    bus4.en   = 1'b1;
    bus4.load = 1'b1;
    bus4.d    = 4'd0;
    bus4.dir  = 1'b0;
    tick();
    n_checks++;
    if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL down_tc_during_load: got %b want 0", bus4.tc); end
    bus4.load = 1'b0;
    #1;
    n_checks++;
    if (bus4.tc !== 1'b1) begin n_fail++; $display("FAIL down_tc_at_zero: got %b want 1", bus4.tc); end
    tick();
    n_checks++;
    if (bus4.q !== 4'd9) begin n_fail++; $display("FAIL down_wrap: got %0d want 9", bus4.q); end
    n_checks++;
    if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL down_tc_at_nine: got %b want 0", bus4.tc); end

    bus4.load = 1'b1;
    bus4.d    = 4'd13;
    bus4.dir  = 1'b1;
    tick();
    bus4.load = 1'b0;
    #1;
    n_checks++;
    if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL oor_tc: got %b want 0", bus4.tc); end
    tick();
    n_checks++;
    if (bus4.q !== 4'd0) begin n_fail++; $display("FAIL oor_up: got %0d want 0", bus4.q); end

    bus4.load = 1'b1;
    bus4.d    = 4'd13;
    bus4.dir  = 1'b0;
    tick();
    bus4.load = 1'b0;
    tick();
    n_checks++;
    if (bus4.q !== 4'd12) begin n_fail++; $display("FAIL oor_down: got %0d want 12", bus4.q); end
  endtask

  // Reset beats load, load beats en = 0; reloading the same value is no change.
  task automatic test_priority();
    rst_n     = 1'b0;
    bus4.load = 1'b1;
    bus4.en   = 1'b1;
    bus4.d    = 4'h7;
    tick();
    n_checks++;
    if (bus4.q !== 4'h5) begin n_fail++; $display("FAIL prio_reset: got %h want 5", bus4.q); end

    rst_n     = 1'b1;
    bus4.en   = 1'b0;
    bus4.mode = 2'b11;
    #1;
    n_checks++;
    if (bus4.tc !== 1'b0) begin n_fail++; $display("FAIL prio_tc: got %b want 0", bus4.tc); end
    tick();
    n_checks++;
    if (bus4.q !== 4'h7) begin n_fail++; $display("FAIL prio_load: got %h want 7", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b1) begin n_fail++; $display("FAIL prio_load_changed: got %b want 1", bus4.changed); end
    tick();
    n_checks++;
    if (bus4.q !== 4'h7) begin n_fail++; $display("FAIL same_load_q: got %h want 7", bus4.q); end
    n_checks++;
    if (bus4.changed !== 1'b0) begin n_fail++; $display("FAIL same_load_changed: got %b want 0", bus4.changed); end
    bus4.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jk();
    test_jk_width1();
    test_d_t();
    test_count_up();
    test_count_down();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jkff_bank.md
Name: jkff_bank

Overview:
- Parametrised successor to the single-bit jkff: a bank of WIDTH JK flip-flops sharing one clock, with a synchronous active-low reset, enable and parallel load.
- Runtime mode select lets the bank act as independent JK, D or T flip-flops, or as a synchronous modulo up/down counter built from JK toggle terms.
- Used as the generic register/counter primitive in the flip-flop and counter lab designs.

Parameters:
- WIDTH, 4: number of flip-flops (bits) in the bank; range 1..16.
- RESET_VAL, 0: value loaded into q on reset; WIDTH bits.
- MODULUS, 2**WIDTH: counter modulus in count mode; range 2..2**WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-low; reset is synchronous and active-low.
- en  input  1  update enable; 0 = hold (load still honoured).
- mode  input  2  00 = JK, 01 = D, 10 = T, 11 = count.
- jk  input  2*WIDTH  per-bit pair: jk[2i+1] = J_i, jk[2i] = K_i (pair value 0 hold, 1 reset, 2 set, 3 toggle).
- d  input  WIDTH  D data in mode 01; per-bit toggle in mode 10; load data.
- load  input  1  parallel load of d into q.
- dir  input  1  count direction in mode 11: 1 = up, 0 = down.
- q  output  WIDTH  registered state.
- qb  output  WIDTH  always ~q (combinational from q).
- tc  output  1  terminal count (combinational).
- changed  output  1  registered; 1 for one cycle after any q bit changed.

Behaviour:
- Priority at each rising clk edge: rst_n = 0, then load = 1, then en = 1, then hold.
- Reset (rst_n = 0 at the edge): q = RESET_VAL, changed = 0. qb = ~RESET_VAL and tc follows q.
  - Asserting reset mid-count takes effect at the next edge.
  - No asynchronous path: before the first edge, q is X in simulation.
- load = 1: q = d in every mode, regardless of en.
- en = 0 and load = 0: q holds.
- Mode 00 (JK), per bit i:
  - J=0, K=0: hold. J=0, K=1: 0. J=1, K=0: 1. J=1, K=1: ~q_i.
  - Bits are fully independent.
- Mode 01 (D): q = d.
- Mode 10 (T): q = q ^ d.
- Mode 11 (count):
  - dir = 1: q = (q >= MODULUS-1) ? 0 : q+1.
  - dir = 0: q = (q == 0) ? MODULUS-1 : q-1.
  - An out-of-range value (>= MODULUS, reached only via load or RESET_VAL) wraps to 0 on the next up-count and decrements normally on a down-count.
  - Arithmetic is WIDTH bits wide; no carry out.
- tc = 1 only when all of the following hold; otherwise 0:
  - mode = 11, en = 1, load = 0, rst_n = 1;
  - and either (dir = 1 and q == MODULUS-1) or (dir = 0 and q == 0).
- changed: registered, set to (q_next != q) at every non-reset edge.
  - A load of the same value, or a hold, gives 0.
- Mode or dir changes take effect at the same edge with no pipeline delay. Latency is 1 clock from input to q in every mode.
- WIDTH = 1 with mode 00 must match the legacy jkff exactly: jk = 0, 1, 2, 3 gives hold, reset, set, toggle.

Test Plan:
- Reset: RESET_VAL = 4'h5, rst_n = 0 for 2 edges with en = 1, mode = 11 -> q = 4'h5, qb = 4'hA, changed = 0. Reset again mid-count -> q = 4'h5 at the next edge.
- JK per bit, WIDTH = 4, starting from q = 4'b0000:
  - jk = 8'b10_01_11_00 -> q = 4'b1010.
  - Same jk again -> q = 4'b1000 (bit 1 toggles back; the others hold or re-assert).
  - WIDTH = 1, jk sequence 0, 1, 2, 3, 3 every 40 ns -> q = X/hold, 0, 1, 0, 1.
- D/T modes: mode = 01, d = 4'hC -> q = 4'hC. Then mode = 10, d = 4'h3 -> q = 4'hF. Then d = 4'hF -> q = 4'h0, changed = 1 on each of these edges.
- Counting up, MODULUS = 10, dir = 1, from load 4'd8:
  - q = 8, 9 (tc = 1 while q = 9), then 0, then 1.
  - en = 0 for 3 edges -> q holds at 1, tc = 0, changed = 0.
- Counting down and out-of-range, MODULUS = 10:
  - From load 0, dir = 0 -> tc = 1, next q = 9.
  - load 4'd13, dir = 1 -> next q = 0.
  - load 4'd13, dir = 0 -> next q = 12.
- Priority: rst_n = 0, load = 1, en = 1 at the same edge -> q = RESET_VAL. Then rst_n = 1, load = 1, en = 0, d = 4'h7 -> q = 4'h7, tc = 0.
